// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction-fetch prefetch stage.
//   - Default address map constants (reset PC, handler entry, legal text window).
//   - Queue entry layout: {pc, instr, adel}, 65 bits.
//   - Redirect-select encoding used by the PC mux.
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO_DEF    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_DEF    = 32'h0000_6ffc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Winning redirect source for the current cycle, highest priority first.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_REQ  = 2'd1,
    SEL_ERET = 2'd2,
    SEL_BR   = 2'd3
  } redir_sel_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: generic DEPTH x DATA_W synchronous FIFO with flush.
// Ports:
//   clk, reset      clock, synchronous active-high reset (control state only)
//   flush           empty the queue; a push in the same cycle lands in the
//                   emptied queue as its only entry
//   push, din       write din at the tail (accepted when not full, or when
//                   full together with an effective pop)
//   pop             advance the head (ignored when empty or flushing)
//   dout            head entry (undefined when empty; the user masks it)
//   full, empty     occupancy flags
//   count           number of stored entries, log2(DEPTH)+1 bits
module ifu_fifo #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_idx;
  logic              do_pop;
  logic              do_push;
  logic              wr_en;

  assign full    = (count == CNT_DEPTH);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // A flushing push always writes slot 0 of the freshly emptied queue.
  assign wr_en   = flush ? push : do_push;
  assign wr_idx  = flush ? '0 : wr_ptr;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_ONE : '0;
      count  <= push ? CNT_ONE : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch stage with PC generator and DEPTH-entry prefetch queue.
// Fetches sequentially while the queue has room; decode pops with out_valid /
// out_ready. Exception entry (req), eret and branch redirects flush the queue.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req                 exception/interrupt taken -> HANDLER_PC
//   eret, epc           exception return -> epc
//   br_valid, br_pc     branch/jump redirect -> br_pc
//   im_addr             fetch address to instruction memory (combinational)
//   im_rdata            instruction memory data for im_addr, same cycle
//   out_valid/out_ready head handshake towards decode
//   out_pc/out_instr    head entry (0 when the queue is empty)
//   out_adel            head fetch raised an address error
// Configuration macro IFU_ERET_BYPASS_EN: when defined, an eret fetches epc in
// the same cycle and enqueues it into the flushed queue (zero-bubble return).
module ifu_prefetch import ifu_pkg::*; #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] TEXT_LO    = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI    = TEXT_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]    pc_p0;
  logic [31:0]    pc_nxt;
  redir_sel_t     sel;
  logic           redirect;
  logic           push;
  logic           pop;
  entry_t         fetch_e;
  entry_t         head_e;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PTR_W:0] fifo_count;

  function automatic logic fetch_adel(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < TEXT_LO) || (a > TEXT_HI);
  endfunction

  always_comb begin
    sel = SEL_NONE;
    if (req)           sel = SEL_REQ;
    else if (eret)     sel = SEL_ERET;
    else if (br_valid) sel = SEL_BR;
  end

  assign redirect = (sel != SEL_NONE);

  always_comb begin
    im_addr = pc_p0;
`ifdef IFU_ERET_BYPASS_EN
    if (sel == SEL_ERET) im_addr = epc;
`endif
  end

  // A faulting fetch is still queued, as a nop, so the exception is raised
  // in program order when decode reaches it.
  always_comb begin
    fetch_e.pc    = im_addr;
    fetch_e.adel  = fetch_adel(im_addr);
    fetch_e.instr = fetch_e.adel ? 32'h0 : im_rdata;
  end

  always_comb begin
    pop  = !redirect && out_ready && !fifo_empty;
    push = !redirect && (!fifo_full || out_ready);
`ifdef IFU_ERET_BYPASS_EN
    if (sel == SEL_ERET) push = 1'b1;
`endif
    case (sel)
      SEL_REQ:  pc_nxt = HANDLER_PC;
`ifdef IFU_ERET_BYPASS_EN
      SEL_ERET: pc_nxt = epc + 32'd4;
`else
      SEL_ERET: pc_nxt = epc;
`endif
      SEL_BR:   pc_nxt = br_pc;
      default:  pc_nxt = push ? (pc_p0 + 32'd4) : pc_p0;
    endcase
  end

  // ---- fetch stage boundary: PC register ----
  always_ff @(posedge clk) begin
    if (reset) pc_p0 <= RESET_PC;
    else       pc_p0 <= pc_nxt;
  end

  // ---- queue boundary: entries become visible to decode one cycle later ----
  ifu_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   (fetch_e),
    .dout  (head_e),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_pc    = fifo_empty ? 32'h0 : head_e.pc;
  assign out_instr = fifo_empty ? 32'h0 : head_e.instr;
  assign out_adel  = fifo_empty ? 1'b0  : head_e.adel;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Testbench for ifu_prefetch: directed scenarios plus a randomized run checked
// against a queue-based reference model. Define IFU_ERET_BYPASS_EN for both
// the bench and the RTL to exercise the zero-bubble eret variant.
module tb_ifu_prefetch;

  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI    = 32'h0000_6ffc;

  logic        clk;
  logic        reset;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  ifu_prefetch #(
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC),
    .HANDLER_PC (HANDLER_PC),
    .TEXT_LO    (TEXT_LO),
    .TEXT_HI    (TEXT_HI)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .eret      (eret),
    .epc       (epc),
    .br_valid  (br_valid),
    .br_pc     (br_pc),
    .im_addr   (im_addr),
    .im_rdata  (im_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_adel  (out_adel)
  );

  // Instruction memory model: data identifies the address it came from.
  assign im_rdata = 32'h1000_0000 | im_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ent_t mk_entry(input logic [31:0] a);
    ent_t e;
    e.pc    = a;
    e.adel  = (a[1:0] != 2'b00) || (a < TEXT_LO) || (a > TEXT_HI);
    e.instr = e.adel ? 32'h0 : (32'h1000_0000 | a);
    return e;
  endfunction

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      11:      return TEXT_LO + 32'd4 * $urandom_range(0, 4095) + 32'd2;
      12:      return TEXT_HI;
      13:      return TEXT_HI + 32'd4;
      14:      return TEXT_LO - 32'd4;
      15:      return 32'hffff_fffc;
      default: return TEXT_LO + 32'd4 * $urandom_range(0, 4095);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; eret = 1'b0; epc = 32'h0; br_valid = 1'b0; br_pc = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    req = 1'b1; br_valid = 1'b1; br_pc = 32'h3100;
    tick();
    idle_inputs();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_checks++; if (out_adel !== 1'b0) begin n_fail++; $display("FAIL reset_adel: got %b want 0", out_adel); end
    n_checks++; if (im_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_im_addr: got %h want %h", im_addr, RESET_PC); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_pc !== 32'h3000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, out_pc, 32'h3000 + 32'(4 * i)); end
      n_checks++; if (out_instr !== 32'h1000_3000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, out_instr, 32'h1000_3000 + 32'(4 * i)); end
      n_checks++; if (out_adel !== 1'b0) begin n_fail++; $display("FAIL seq_adel[%0d]: got %b want 0", i, out_adel); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    n_checks++; if (im_addr !== 32'h3010) begin n_fail++; $display("FAIL stall_im_addr: got %h want 00003010", im_addr); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 32'h3000) begin n_fail++; $display("FAIL stall_head: got %h want 00003000", out_pc); end
  endtask

  task automatic test_full_deq_enq();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_pc !== 32'h3004) begin n_fail++; $display("FAIL full_deq_head: got %h want 00003004", out_pc); end
    n_checks++; if (im_addr !== 32'h3014) begin n_fail++; $display("FAIL full_enq_addr: got %h want 00003014", im_addr); end
    tick();
    n_checks++; if (im_addr !== 32'h3014) begin n_fail++; $display("FAIL full_hold_addr: got %h want 00003014", im_addr); end
    n_checks++; if (out_pc !== 32'h3004) begin n_fail++; $display("FAIL full_hold_head: got %h want 00003004", out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (out_pc !== 32'h3008 + 32'(4 * i)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h want %h", i, out_pc, 32'h3008 + 32'(4 * i)); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    repeat (5) tick();
    req = 1'b1; br_valid = 1'b1; br_pc = 32'h3100;
    tick();
    idle_inputs();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL flush_pc_masked: got %h want 0", out_pc); end
    n_checks++; if (im_addr !== HANDLER_PC) begin n_fail++; $display("FAIL flush_im_addr: got %h want %h", im_addr, HANDLER_PC); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL handler_valid: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== HANDLER_PC) begin n_fail++; $display("FAIL handler_pc: got %h want %h", out_pc, HANDLER_PC); end
    n_checks++; if (out_instr !== (32'h1000_0000 | HANDLER_PC)) begin n_fail++; $display("FAIL handler_instr: got %h want %h", out_instr, 32'h1000_0000 | HANDLER_PC); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_pc !== HANDLER_PC + 32'd4) begin n_fail++; $display("FAIL handler_next: got %h want %h", out_pc, HANDLER_PC + 32'd4); end
  endtask

  task automatic test_adel();
    logic [31:0] addrs [5];
    logic        adels [5];
    logic [31:0] exp_instr;
    addrs = '{32'h3002, 32'h7000, 32'h6ffc, 32'h2ffc, 32'h3000};
    adels = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_valid = 1'b1; br_pc = addrs[i];
      tick();
      idle_inputs();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble[%0d]: got %b want 0", i, out_valid); end
      tick();
      exp_instr = adels[i] ? 32'h0 : (32'h1000_0000 | addrs[i]);
      n_checks++; if (out_pc !== addrs[i]) begin n_fail++; $display("FAIL adel_pc[%0d]: got %h want %h", i, out_pc, addrs[i]); end
      n_checks++; if (out_adel !== adels[i]) begin n_fail++; $display("FAIL adel_flag[%0d]: got %b want %b", i, out_adel, adels[i]); end
      n_checks++; if (out_instr !== exp_instr) begin n_fail++; $display("FAIL adel_instr[%0d]: got %h want %h", i, out_instr, exp_instr); end
    end
  endtask

  task automatic test_eret();
    out_ready = 1'b0;
    br_valid = 1'b1; br_pc = 32'h3200;
    tick();
    idle_inputs();
    eret = 1'b1; epc = 32'h3040;
    #1;
`ifdef IFU_ERET_BYPASS_EN
    n_checks++; if (im_addr !== 32'h3040) begin n_fail++; $display("FAIL eret_bypass_addr: got %h want 00003040", im_addr); end
`else
    n_checks++; if (im_addr !== 32'h3200) begin n_fail++; $display("FAIL eret_addr_hold: got %h want 00003200", im_addr); end
`endif
    tick();
    idle_inputs();
`ifdef IFU_ERET_BYPASS_EN
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL eret_valid_n1: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 32'h3040) begin n_fail++; $display("FAIL eret_pc_n1: got %h want 00003040", out_pc); end
    n_checks++; if (im_addr !== 32'h3044) begin n_fail++; $display("FAIL eret_next_addr: got %h want 00003044", im_addr); end
`else
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL eret_bubble: got %b want 0", out_valid); end
    n_checks++; if (im_addr !== 32'h3040) begin n_fail++; $display("FAIL eret_addr_n1: got %h want 00003040", im_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL eret_valid_n2: got %b want 1", out_valid); end
    n_checks++; if (out_pc !== 32'h3040) begin n_fail++; $display("FAIL eret_pc_n2: got %h want 00003040", out_pc); end
`endif
  endtask

  task automatic model_step();
    bit deq;
    bit enq;
    if (reset) begin
      m_pc = RESET_PC;
      mq.delete();
    end else if (req) begin
      mq.delete();
      m_pc = HANDLER_PC;
    end else if (eret) begin
      mq.delete();
`ifdef IFU_ERET_BYPASS_EN
      mq.push_back(mk_entry(epc));
      m_pc = epc + 32'd4;
`else
      m_pc = epc;
`endif
    end else if (br_valid) begin
      mq.delete();
      m_pc = br_pc;
    end else begin
      deq = (mq.size() > 0) && out_ready;
      enq = (mq.size() < DEPTH) || out_ready;
      if (deq) void'(mq.pop_front());
      if (enq) begin
        mq.push_back(mk_entry(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_addr;
    ent_t        head;
    int          ready_pct;
    do_reset();
    m_pc = RESET_PC;
    mq.delete();
    ready_pct = 75;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) ready_pct = $urandom_range(10, 100);
      reset     = ($urandom_range(0, 299) == 0);
      req       = ($urandom_range(0, 49) == 0);
      eret      = ($urandom_range(0, 39) == 0);
      br_valid  = ($urandom_range(0, 19) == 0);
      epc       = pick_addr();
      br_pc     = pick_addr();
      out_ready = ($urandom_range(1, 100) <= ready_pct);
      #1;
      exp_addr = m_pc;
`ifdef IFU_ERET_BYPASS_EN
      if (eret && !req) exp_addr = epc;
`endif
      if (mq.size() > 0) head = mq[0];
      else begin head.pc = 32'h0; head.instr = 32'h0; head.adel = 1'b0; end
      n_checks++; if (im_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_im_addr @%0d: got %h want %h", cyc, im_addr, exp_addr); end
      n_checks++; if (out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, out_valid, mq.size() > 0); end
      n_checks++; if (out_pc !== head.pc) begin n_fail++; $display("FAIL rnd_pc @%0d: got %h want %h", cyc, out_pc, head.pc); end
      n_checks++; if (out_instr !== head.instr) begin n_fail++; $display("FAIL rnd_instr @%0d: got %h want %h", cyc, out_instr, head.instr); end
      n_checks++; if (out_adel !== head.adel) begin n_fail++; $display("FAIL rnd_adel @%0d: got %b want %b", cyc, out_adel, head.adel); end
      @(posedge clk);
      model_step();
      #1;
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_stall();
    test_full_deq_enq();
    test_flush();
    test_adel();
    test_eret();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
